// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and opcode classification for the
// multi-cycle ALU and its iterative multiply/divide unit.
package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] ALU_AND   = 4'b0000;
  localparam logic [OP_W-1:0] ALU_OR    = 4'b0001;
  localparam logic [OP_W-1:0] ALU_ADD   = 4'b0010;
  localparam logic [OP_W-1:0] ALU_XOR   = 4'b0011;
  localparam logic [OP_W-1:0] ALU_SLL   = 4'b0100;
  localparam logic [OP_W-1:0] ALU_SRL   = 4'b0101;
  localparam logic [OP_W-1:0] ALU_SUB   = 4'b0110;
  localparam logic [OP_W-1:0] ALU_MINU  = 4'b0111;
  localparam logic [OP_W-1:0] ALU_MUL   = 4'b1000;
  localparam logic [OP_W-1:0] ALU_MULHU = 4'b1001;
  localparam logic [OP_W-1:0] ALU_DIVU  = 4'b1010;
  localparam logic [OP_W-1:0] ALU_REMU  = 4'b1011;
  localparam logic [OP_W-1:0] ALU_NOR   = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic is_multicycle(input logic [OP_W-1:0] op);
    return (op == ALU_MUL) || (op == ALU_MULHU) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

  function automatic logic is_div(input logic [OP_W-1:0] op);
    return (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / restoring divide, one bit per step.
// A single 2*WIDTH register holds {hi, lo} of the product or {remainder, quotient}.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_i,
  input  logic             div_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] lo_next_o,
  output logic [WIDTH-1:0] hi_next_o
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [CNT_W-1:0]   cnt_q;
  logic               div_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_fits;
  logic [WIDTH-1:0]   div_rem;

  assign last_o = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    // Multiply: add multiplicand into the upper half when the LSB is set, then shift right.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    // Divide: W+1-bit partial remainder gets the next dividend bit shifted in.
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_fits  = (div_shift >= {1'b0, mcand_q});
    div_rem   = div_fits ? WIDTH'(div_shift - {1'b0, mcand_q}) : div_shift[WIDTH-1:0];
    acc_d     = acc_q;
    if (div_q) begin
      acc_d = {div_rem, acc_q[WIDTH-2:0], div_fits};
    end else if (acc_q[0]) begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end else begin
      acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
    end
  end

  assign lo_next_o = acc_d[WIDTH-1:0];
  assign hi_next_o = acc_d[2*WIDTH-1:WIDTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      div_q   <= 1'b0;
      mcand_q <= '0;
      acc_q   <= '0;
    end else if (start_i) begin
      cnt_q   <= '0;
      div_q   <= div_i;
      mcand_q <= div_i ? op_b_i : op_a_i;
      acc_q   <= {{WIDTH{1'b0}}, (div_i ? op_a_i : op_b_i)};
    end else if (step_i) begin
      cnt_q   <= last_o ? '0 : cnt_q + 1'b1;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Valid/ready ALU: single-cycle logic/arith/shift ops plus iterative MUL/DIV.
// One op in flight; the result is held in DONE until the consumer takes it.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  operation,
  input  logic [WIDTH-1:0] data_0,
  input  logic [WIDTH-1:0] data_1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero
);

  state_t           state_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             overflow_q;
  logic             dbz_q;
  logic             hi_sel_q;

  logic             accept;
  logic             op_multi;
  logic             op_div;
  logic             divisor_zero;
  logic             iter_start;
  logic             iter_step;
  logic             iter_last;
  logic [WIDTH-1:0] iter_lo;
  logic [WIDTH-1:0] iter_hi;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

  assign in_ready     = (state_q == S_IDLE);
  assign out_valid    = (state_q == S_DONE);
  assign result       = result_q;
  assign zero         = zero_q;
  assign overflow     = overflow_q;
  assign div_by_zero  = dbz_q;

  assign accept       = in_valid && in_ready;
  assign op_multi     = is_multicycle(operation);
  assign op_div       = is_div(operation);
  assign divisor_zero = (data_1 == '0);
  assign iter_start   = accept && op_multi && !(op_div && divisor_zero);
  assign iter_step    = (state_q == S_MUL) || (state_q == S_DIV);

  always_comb begin
    sum     = data_0 + data_1;
    diff    = data_0 - data_1;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (operation)
      ALU_AND:  alu_res = data_0 & data_1;
      ALU_OR:   alu_res = data_0 | data_1;
      ALU_XOR:  alu_res = data_0 ^ data_1;
      ALU_NOR:  alu_res = ~(data_0 | data_1);
      ALU_ADD: begin
        alu_res = sum;
        alu_ovf = (data_0[WIDTH-1] == data_1[WIDTH-1]) && (sum[WIDTH-1] != data_0[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = diff;
        alu_ovf = (data_0[WIDTH-1] != data_1[WIDTH-1]) && (diff[WIDTH-1] != data_0[WIDTH-1]);
      end
      ALU_MINU: alu_res = (data_0 < data_1) ? data_0 : data_1;
      ALU_SLL:  alu_res = data_0 << data_1[SHW-1:0];
      ALU_SRL:  alu_res = data_0 >> data_1[SHW-1:0];
      default:  alu_res = '0;
    endcase
  end

  alu_muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clock     (clock),
    .reset     (reset),
    .start_i   (iter_start),
    .div_i     (op_div),
    .step_i    (iter_step),
    .op_a_i    (data_0),
    .op_b_i    (data_1),
    .last_o    (iter_last),
    .lo_next_o (iter_lo),
    .hi_next_o (iter_hi)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      result_q   <= '0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
      dbz_q      <= 1'b0;
      hi_sel_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            zero_q     <= (data_0 == data_1);
            overflow_q <= 1'b0;
            dbz_q      <= 1'b0;
            hi_sel_q   <= (operation == ALU_MULHU) || (operation == ALU_REMU);
            if (op_div && divisor_zero) begin
              // Divide by zero short-circuits: quotient all ones, remainder is the dividend.
              result_q <= (operation == ALU_DIVU) ? '1 : data_0;
              dbz_q    <= 1'b1;
              state_q  <= S_DONE;
            end else if (op_multi) begin
              state_q <= op_div ? S_DIV : S_MUL;
            end else begin
              result_q   <= alu_res;
              overflow_q <= alu_ovf;
              state_q    <= S_DONE;
            end
          end
        end
        S_MUL, S_DIV: begin
          if (iter_last) begin
            result_q <= hi_sel_q ? iter_hi : iter_lo;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed corner cases, stall, reset
// abort, then randomized ops checked against an arithmetic reference model.
module tb_alu_multicycle;
  import alu_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  operation;
  logic [31:0] data_0;
  logic [31:0] data_1;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        div_by_zero;

  int checks = 0;
  int passed = 0;

  alu_multicycle #(.WIDTH(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .operation   (operation),
    .data_0      (data_0),
    .data_1      (data_1),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference model straight from the opcode table, using wide integer arithmetic.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ov, output logic dz,
                                output int lat);
    longint     s;
    logic [63:0] p;
    r = 32'd0; ov = 1'b0; dz = 1'b0; lat = 1;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0011: r = a ^ b;
      4'b1100: r = ~(a | b);
      4'b0010: begin
        s  = longint'($signed(a)) + longint'($signed(b));
        r  = a + b;
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0110: begin
        s  = longint'($signed(a)) - longint'($signed(b));
        r  = a - b;
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0111: r = (a < b) ? a : b;
      4'b0100: r = a << (b % 32);
      4'b0101: r = a >> (b % 32);
      4'b1000: begin p = 64'(a) * 64'(b); r = p[31:0];  lat = 33; end
      4'b1001: begin p = 64'(a) * 64'(b); r = p[63:32]; lat = 33; end
      4'b1010: begin
        if (b == 0) begin r = 32'hFFFF_FFFF; dz = 1'b1; end
        else begin r = a / b; lat = 33; end
      end
      4'b1011: begin
        if (b == 0) begin r = a; dz = 1'b1; end
        else begin r = a % b; lat = 33; end
      end
      default: r = 32'd0;
    endcase
  endfunction

  // One transaction: accept, wait for out_valid with junk on the inputs,
  // optionally stall the consumer, then hand the result off.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int stall);
    logic [31:0] er;
    logic        eov, edz;
    int          elat, lat;
    logic        busy_ok;
    model(op, a, b, er, eov, edz, elat);
    @(negedge clock);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    in_valid = 1'b1; operation = op; data_0 = a; data_1 = b;
    out_ready = (stall == 0);
    @(posedge clock); #1;
    operation = 4'($urandom); data_0 = $urandom; data_1 = $urandom;
    lat = 1;
    busy_ok = 1'b1;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clock); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_busy_in_ready"}, busy_ok, 1'b1);
    chk({tag, "_result"}, result, er);
    chk({tag, "_zero"}, zero, (a == b));
    chk({tag, "_overflow"}, overflow, eov);
    chk({tag, "_div_by_zero"}, div_by_zero, edz);
    for (int i = 0; i < stall; i++) begin
      @(posedge clock); #1;
      operation = 4'($urandom); data_0 = $urandom; data_1 = $urandom;
      chk({tag, "_stall_valid"}, out_valid, 1'b1);
      chk({tag, "_stall_result"}, result, er);
      chk({tag, "_stall_in_ready"}, in_ready, 1'b0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clock); #1;
    chk({tag, "_handoff"}, {out_valid, in_ready}, 2'b01);
    $display("txn %s op=%b a=%h b=%h result=%h expected=%h lat=%0d", tag, op, a, b, result, er, lat);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [3:0]  rop;
    reset = 1'b1; in_valid = 1'b0; operation = '0; data_0 = '0; data_1 = '0; out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {zero, overflow, div_by_zero}, 3'b000);
    reset = 1'b0;

    run_op("add_ovf",   ALU_ADD,   32'h7FFF_FFFF, 32'h1,          0);
    run_op("sub_ovf",   ALU_SUB,   32'h8000_0000, 32'h1,          0);
    run_op("mul_lo",    ALU_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF,  0);
    run_op("mul_hi",    ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  0);
    run_op("divu",      ALU_DIVU,  32'd100,       32'd7,          0);
    run_op("remu",      ALU_REMU,  32'd100,       32'd7,          0);
    run_op("divu_zero", ALU_DIVU,  32'd5,         32'd0,          0);
    run_op("remu_zero", ALU_REMU,  32'd5,         32'd0,          0);
    run_op("minu",      ALU_MINU,  32'd3,         32'hFFFF_FFFF,  0);
    run_op("sll_wrap",  ALU_SLL,   32'd1,         32'h21,         0);
    run_op("srl",       ALU_SRL,   32'h8000_0000, 32'hFFFF_FFE4,  0);
    run_op("xor_eq",    ALU_XOR,   32'h1234_5678, 32'h1234_5678,  0);
    run_op("nor",       ALU_NOR,   32'h0F0F_0000, 32'h0000_00F0,  0);
    run_op("bad_op",    4'b1101,   32'hDEAD_BEEF, 32'h1,          0);
    run_op("stall",     ALU_DIVU,  32'hFFFF_FFF0, 32'd3,          5);

    // Abort a divide part-way through with reset.
    @(negedge clock);
    in_valid = 1'b1; operation = ALU_DIVU; data_0 = 32'd1000; data_1 = 32'd9;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_result", result, 32'd0);
    repeat (40) begin
      @(posedge clock); #1;
      if (out_valid !== 1'b0) break;
    end
    chk("abort_stays_idle", {out_valid, in_ready}, 2'b01);
    run_op("after_abort", ALU_REMU, 32'd1000, 32'd9, 0);

    for (int n = 0; n < 40; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = 32'd0;
        2:       rb = 32'($urandom_range(1, 40));
        default: rb = $urandom;
      endcase
      run_op($sformatf("rnd%0d", n), rop, ra, rb, (n % 7 == 3) ? 2 : 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
